// File: rtl/lane_traffic_ctrl_pkg.sv
// Shared game constants: game-state encodings, screen width, sprite sizes,
// and the move-tick period rule used by the traffic controller.
package lane_traffic_ctrl_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'b00,
        GS_RUN   = 2'b01,
        GS_WIN   = 2'b10,
        GS_CLEAN = 2'b11
    } game_state_e;

    localparam int GAME_POS_W    = 10;
    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_CAR_W    = 32;
    localparam int GAME_CAR_H    = 32;
    localparam int GAME_PLAYER_W = 32;
    localparam int GAME_PLAYER_H = 32;

    // Period shrinks by level_dec per level but never drops below min_div.
    function automatic logic [31:0] calc_period(input logic [3:0]  level,
                                                input logic [31:0] base_div,
                                                input logic [31:0] level_dec,
                                                input logic [31:0] min_div);
        logic [35:0] dec;
        dec = 36'(level) * 36'(level_dec);
        if (dec >= 36'(base_div)) begin
            return min_div;
        end else if ((36'(base_div) - dec) < 36'(min_div)) begin
            return min_div;
        end else begin
            return base_div - dec[31:0];
        end
    endfunction

endpackage

// File: rtl/lane_traffic_ctrl_if.sv
// Bundle of the game-side signals around the traffic controller: game inputs
// travel master -> slave, car positions and hit status travel slave -> master.
interface lane_traffic_ctrl_if #(
    parameter int N_LANES = 3,
    parameter int HIT_W   = 2
);
    logic [1:0]             game_state;
    logic [3:0]             level;
    logic [9:0]             player_x;
    logic [9:0]             player_y;
    logic [10*N_LANES-1:0]  car_x;
    logic [10*N_LANES-1:0]  car_y;
    logic                   collision;
    logic [HIT_W-1:0]       hit_lane;
    logic                   invuln;

    modport master (
        output game_state, level, player_x, player_y,
        input  car_x, car_y, collision, hit_lane, invuln
    );

    modport slave (
        input  game_state, level, player_x, player_y,
        output car_x, car_y, collision, hit_lane, invuln
    );
endinterface

// File: rtl/lane_traffic_ctrl_lane_mover.sv
// One car lane: X register that steps one pixel per move tick in a fixed
// direction and wraps around the screen edge.
module lane_mover
    import lane_traffic_ctrl_pkg::*;
#(
    parameter int         SCREEN_W   = GAME_SCREEN_W,
    parameter logic [9:0] HOME_X     = 10'd0,
    parameter bit         MOVE_RIGHT = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Hold_Home,
    input  logic       i_Tick,
    output logic [9:0] o_X
);

    logic [9:0] x_q;
    logic [9:0] x_d;

    always_comb begin
        x_d = x_q;
        if (i_Hold_Home) begin
            x_d = HOME_X;
        end else if (i_Tick) begin
            if (MOVE_RIGHT) begin
                x_d = (x_q == 10'(SCREEN_W - 1)) ? 10'd0 : x_q + 10'd1;
            end else begin
                x_d = (x_q == 10'd0) ? 10'(SCREEN_W - 1) : x_q - 10'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            x_q <= HOME_X;
        end else begin
            x_q <= x_d;
        end
    end

    assign o_X = x_q;

endmodule

// File: rtl/lane_traffic_ctrl.sv
// Car-lane traffic: shared move-tick prescaler, per-lane movers, two-stage
// player/car collision detection with a post-hit immunity window.
module lane_traffic_ctrl
    import lane_traffic_ctrl_pkg::*;
#(
    parameter int                    N_LANES        = 3,
    parameter int                    SCREEN_W       = GAME_SCREEN_W,
    parameter int                    LANE_Y0        = 128,
    parameter int                    LANE_PITCH     = 32,
    parameter int                    LANE_X_SPACING = 100,
    parameter logic [N_LANES-1:0]    LANE_DIR_MASK  = 3'b101,
    parameter int                    CAR_W          = GAME_CAR_W,
    parameter int                    CAR_H          = GAME_CAR_H,
    parameter int                    PLAYER_W       = GAME_PLAYER_W,
    parameter int                    PLAYER_H       = GAME_PLAYER_H,
    parameter int unsigned           BASE_DIV       = 250000,
    parameter int unsigned           LEVEL_DEC      = 20000,
    parameter int unsigned           MIN_DIV        = 50000,
    parameter int unsigned           INVULN_CYCLES  = 25000000,
    localparam int                   HIT_W          = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [1:0]              i_Game_State,
    input  logic [3:0]              i_Level,
    input  logic [9:0]              i_Player_X,
    input  logic [9:0]              i_Player_Y,
    output logic [10*N_LANES-1:0]   o_Car_X,
    output logic [10*N_LANES-1:0]   o_Car_Y,
    output logic                    o_Collision,
    output logic [HIT_W-1:0]        o_Hit_Lane,
    output logic                    o_Invuln
);

    game_state_e game_state;
    logic        run;
    logic        idle;

    assign game_state = game_state_e'(i_Game_State);
    assign run        = (game_state == GS_RUN);
    assign idle       = (game_state == GS_IDLE);

    logic [31:0] reload_period;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic        tick;

    assign reload_period = calc_period(i_Level, 32'(BASE_DIV), 32'(LEVEL_DEC), 32'(MIN_DIV));

    // The period is latched only on reload, so a level change waits for the next period.
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        tick     = 1'b0;
        if (idle) begin
            cnt_d    = 32'd0;
            period_d = reload_period;
        end else if (run) begin
            if (cnt_q + 32'd1 >= period_q) begin
                tick     = 1'b1;
                cnt_d    = 32'd0;
                period_d = reload_period;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            cnt_q    <= 32'd0;
            period_q <= reload_period;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_mover #(
            .SCREEN_W   (SCREEN_W),
            .HOME_X     (10'((g * LANE_X_SPACING) % SCREEN_W)),
            .MOVE_RIGHT (LANE_DIR_MASK[g])
        ) u_lane_mover (
            .i_Clk       (i_Clk),
            .i_Reset     (i_Reset),
            .i_Hold_Home (idle),
            .i_Tick      (tick),
            .o_X         (o_Car_X[10*g +: 10])
        );
        assign o_Car_Y[10*g +: 10] = 10'(LANE_Y0 + g * LANE_PITCH);
    end

    logic [N_LANES-1:0] ov_now;
    logic [N_LANES-1:0] ov_q, ov_d;
    logic [10:0]        px, py;

    assign px = {1'b0, i_Player_X};
    assign py = {1'b0, i_Player_Y};

    // Box edges are summed at 11 bits so nothing wraps at the screen edge.
    always_comb begin
        logic [10:0] cx;
        logic [10:0] cy;
        ov_now = '0;
        cx     = 11'd0;
        cy     = 11'd0;
        for (int i = 0; i < N_LANES; i++) begin
            cx = {1'b0, o_Car_X[10*i +: 10]};
            cy = {1'b0, o_Car_Y[10*i +: 10]};
            ov_now[i] = (px < cx + 11'(CAR_W)) && (px + 11'(PLAYER_W) > cx) &&
                        (py < cy + 11'(CAR_H)) && (py + 11'(PLAYER_H) > cy);
        end
    end

    logic [HIT_W-1:0] low_lane;
    logic [HIT_W-1:0] hit_q, hit_d;
    logic [31:0]      inv_q, inv_d;
    logic             coll_q, coll_d;

    always_comb begin
        low_lane = '0;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (ov_q[i]) begin
                low_lane = HIT_W'(i);
            end
        end
    end

    always_comb begin
        ov_d   = idle ? '0 : ov_now;
        coll_d = run && (|ov_q) && (inv_q == 32'd0);
        hit_d  = hit_q;
        inv_d  = inv_q;
        if (idle) begin
            hit_d = '0;
            inv_d = 32'd0;
        end else if (coll_d) begin
            hit_d = low_lane;
            inv_d = 32'(INVULN_CYCLES);
        end else if (run && inv_q != 32'd0) begin
            inv_d = inv_q - 32'd1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            ov_q   <= '0;
            coll_q <= 1'b0;
            hit_q  <= '0;
            inv_q  <= 32'd0;
        end else begin
            ov_q   <= ov_d;
            coll_q <= coll_d;
            hit_q  <= hit_d;
            inv_q  <= inv_d;
        end
    end

    assign o_Collision = coll_q;
    assign o_Hit_Lane  = hit_q;
    assign o_Invuln    = (inv_q != 32'd0);

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Bench for lane_traffic_ctrl: directed scenarios plus random play, every
// cycle compared against a tick-count based model of the lanes and hits.
module tb_lane_traffic_ctrl;
    import lane_traffic_ctrl_pkg::*;

    localparam int N      = 3;
    localparam int HIT_W  = 2;
    localparam int SW     = 640;
    localparam int BASE   = 10;
    localparam int DEC    = 2;
    localparam int MIN    = 4;
    localparam int INV    = 20;
    localparam logic [2:0] DIR = 3'b101;

    logic clk;
    logic rst;

    lane_traffic_ctrl_if #(.N_LANES(N), .HIT_W(HIT_W)) bus ();

    lane_traffic_ctrl #(
        .BASE_DIV      (BASE),
        .LEVEL_DEC     (DEC),
        .MIN_DIV       (MIN),
        .INVULN_CYCLES (INV)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Game_State (bus.game_state),
        .i_Level      (bus.level),
        .i_Player_X   (bus.player_x),
        .i_Player_Y   (bus.player_y),
        .o_Car_X      (bus.car_x),
        .o_Car_Y      (bus.car_y),
        .o_Collision  (bus.collision),
        .o_Hit_Lane   (bus.hit_lane),
        .o_Invuln     (bus.invuln)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: lane positions derive from a tick count since the last home
    int m_ticks, m_cyc, m_p, m_inv, m_hit;
    bit m_coll;
    bit m_ov [N];

    function automatic int period_of(int level);
        int p;
        p = BASE - level * DEC;
        return (p < MIN) ? MIN : p;
    endfunction

    function automatic int model_x(int i);
        int h, t;
        h = (i * 100) % SW;
        t = m_ticks % SW;
        if (DIR[i]) return (h + t) % SW;
        return (h - t + SW) % SW;
    endfunction

    function automatic int lane_y(int i);
        return 128 + 32 * i;
    endfunction

    function automatic bit boxes_touch(int cx, int cy, int px, int py);
        return (px < cx + 32) && (px + 32 > cx) && (py < cy + 32) && (py + 32 > cy);
    endfunction

    task automatic model_edge();
        bit ov_now [N];
        bit any_ov, run, idle, coll_new;
        int low;
        run  = (bus.game_state == 2'b01);
        idle = (bus.game_state == 2'b00);
        any_ov = 0;
        low = 0;
        for (int i = N - 1; i >= 0; i--) begin
            ov_now[i] = boxes_touch(model_x(i), lane_y(i), int'(bus.player_x), int'(bus.player_y));
            if (m_ov[i]) begin
                any_ov = 1;
                low = i;
            end
        end
        coll_new = run && any_ov && (m_inv == 0);
        if (rst || idle) begin
            m_ticks = 0;
            m_cyc   = 0;
            m_p     = period_of(int'(bus.level));
            m_coll  = 0;
            m_hit   = 0;
            m_inv   = 0;
            for (int i = 0; i < N; i++) m_ov[i] = 0;
        end else begin
            if (run) begin
                m_cyc++;
                if (m_cyc == m_p) begin
                    m_ticks++;
                    m_cyc = 0;
                    m_p   = period_of(int'(bus.level));
                end
            end
            m_coll = coll_new;
            if (coll_new) begin
                m_hit = low;
                m_inv = INV;
            end else if (run && m_inv > 0) begin
                m_inv--;
            end
            for (int i = 0; i < N; i++) m_ov[i] = ov_now[i];
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            check($sformatf("car_x%0d", i), int'(bus.car_x[10*i +: 10]), model_x(i));
            check($sformatf("car_y%0d", i), int'(bus.car_y[10*i +: 10]), lane_y(i));
        end
        check("collision", int'(bus.collision), int'(m_coll));
        check("hit_lane", int'(bus.hit_lane), m_hit);
        check("invuln", int'(bus.invuln), int'(m_inv != 0));
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic [1:0] st, input int lvl, input int px, input int py);
        bus.game_state = st;
        bus.level      = 4'(lvl);
        bus.player_x   = 10'(px);
        bus.player_y   = 10'(py);
    endtask

    int first_at, second_at, pulses, first_hit, guard;

    initial begin
        rst = 1'b1;
        drive(2'b01, 0, 0, 0);
        m_ticks = 0; m_cyc = 0; m_p = BASE; m_inv = 0; m_hit = 0; m_coll = 0;
        for (int i = 0; i < N; i++) m_ov[i] = 0;
        repeat (3) step();

        // first tick after ten running cycles
        rst = 1'b0;
        repeat (10) step();
        check("first_tick_lane0", int'(bus.car_x[9:0]), 1);
        check("first_tick_lane1", int'(bus.car_x[19:10]), 99);
        repeat (3) step();

        // level change mid-period takes effect at the next reload
        bus.level = 4'd5;
        repeat (30) step();

        // long run past both wrap points, with random pauses
        guard = 0;
        while (m_ticks < 640 && guard < 8000) begin
            if ($urandom_range(0, 49) == 0) begin
                bus.game_state = 2'($urandom_range(2, 3));
                repeat ($urandom_range(1, 20)) step();
                bus.game_state = 2'b01;
            end
            step();
            guard++;
        end
        check("wrap_reached", int'(m_ticks >= 640), 1);
        check("wrap_lane0", int'(bus.car_x[9:0]), 0);

        // single-lane hit, immunity window, then one repeat pulse
        drive(2'b00, 0, 0, 0);
        repeat (2) step();
        drive(2'b01, 0, 110, 160);
        first_at = -1; second_at = -1; pulses = 0; first_hit = -1;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (bus.collision) begin
                pulses++;
                if (first_at < 0) begin
                    first_at  = k;
                    first_hit = int'(bus.hit_lane);
                end else if (second_at < 0) begin
                    second_at = k;
                end
            end
        end
        check("hit_latency", first_at, 2);
        check("hit_lane_first", first_hit, 1);
        check("repeat_pulse_at", second_at, 23);
        check("pulse_count", pulses, 2);

        // freeze in win state, then resume countdown
        bus.game_state = 2'b10;
        repeat (50) step();
        bus.game_state = 2'b01;
        repeat (30) step();
        bus.game_state = 2'b11;
        repeat (10) step();
        bus.game_state = 2'b01;
        repeat (5) step();

        // reset mid-immunity
        rst = 1'b1;
        step();
        check("reset_invuln", int'(bus.invuln), 0);
        rst = 1'b0;
        drive(2'b00, 0, 110, 160);
        step();
        drive(2'b01, 0, 110, 160);
        repeat (6) step();
        // idle mid-immunity
        bus.game_state = 2'b00;
        step();
        check("idle_invuln", int'(bus.invuln), 0);
        check("idle_hit_lane", int'(bus.hit_lane), 0);
        step();

        // two lanes overlap together: lowest index wins
        drive(2'b01, 5, 50, 144);
        first_hit = -1;
        for (int k = 0; k < 120; k++) begin
            step();
            if (bus.collision && first_hit < 0) first_hit = int'(bus.hit_lane);
        end
        check("priority_lane", first_hit, 0);

        // random play
        for (int k = 0; k < 120; k++) begin
            if ($urandom_range(0, 29) == 0) rst = 1'b1;
            case ($urandom_range(0, 9))
                0:       bus.game_state = 2'b00;
                1:       bus.game_state = 2'b10;
                2:       bus.game_state = 2'b11;
                default: bus.game_state = 2'b01;
            endcase
            bus.level    = 4'($urandom_range(0, 15));
            bus.player_x = 10'($urandom_range(0, 639));
            bus.player_y = 10'($urandom_range(100, 230));
            repeat ($urandom_range(1, 40)) begin
                step();
                rst = 1'b0;
                if ($urandom_range(0, 7) == 0) bus.player_x = 10'($urandom_range(0, 639));
            end
        end

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
